bus_switch: RTL and testbench
=============================

// Module: bus_switch
// PURPOSE
//  Parametrised bus interconnect between the CPU master port and NSLV slaves:
//  address decode, slave strobe generation, read-data/ack multiplexing.
//  Adds bus-error handling: unmapped accesses and slave timeouts complete with m_err.
//  The faulting access is captured and raised as a sticky error interrupt.
//  Sits in the top level between cpu and all memory/I/O devices.
// PARAMETERS
//  NSLV   12          number of slave ports (1..16)
//  BASE   {NSLV{30'h0}} packed word-address bases; slave i at [30*i+:30]
//  MASK   {NSLV{30'h0}} packed compare masks; slave i at [30*i+:30]; 1 = bit compared
//  TMO    255         timeout: max wait cycles for slave ack (2..2**TMO_W-1)
//  TMO_W  8           timeout counter width
// PORTS
//  clk        in   1        system clock
//  rst_n      in   1        asynchronous reset, active low
//  m_stb      in   1        master strobe, held until m_ack
//  m_we       in   1        master write enable
//  m_addr     in   30       master word address [31:2]
//  m_din      out  32       read data to master
//  m_ack      out  1        master acknowledge
//  m_err      out  1        bus error; valid only with m_ack
//  s_stb      out  NSLV     one-hot slave strobes
//  s_dout     in   32*NSLV  slave read data, slave i at [32*i+:32]
//  s_ack      in   NSLV     slave acknowledges
//  err_irq    out  1        sticky bus-error interrupt
//  err_addr   out  30       captured faulting word address
//  err_we     out  1        captured write flag of faulting access
//  err_tmo    out  1        captured cause: 1 = timeout, 0 = unmapped
//  err_clr    in   1        clears err_irq (one-cycle pulse)
// BEHAVIOUR
//  - Decode: hit[i] = ((m_addr ^ BASE_i) & MASK_i) == 0; lowest hit index wins.
//  - States IDLE, BUSY, ERR; reset -> IDLE, cnt=0, all outputs 0.
//  - IDLE/BUSY, m_stb=1, hit: s_stb[sel]=1 combinationally (zero added latency).
//    m_din=s_dout[sel] and m_ack=s_ack[sel] in the same cycle; state BUSY while unacked.
//  - m_ack=1 from slave: cnt<=0, state IDLE; back-to-back stb next cycle allowed.
//  - BUSY counting: cnt increments each cycle stb is held without ack.
//    Ack in the cycle cnt==TMO-1: normal completion. No ack at cnt==TMO-1: next state ERR.
//  - IDLE/BUSY, m_stb=1, no hit: s_stb=0, next state ERR (error ack 1 cycle later).
//  - ERR: exactly one cycle; m_ack=1, m_err=1, m_din=0, s_stb all 0 (slave aborted).
//    A late s_ack in this cycle is ignored. Next state IDLE, cnt<=0.
//  - m_stb=0: s_stb=0, m_ack=0, m_din=0, cnt<=0, state IDLE (from BUSY too).
//  - Capture on entry to ERR: if err_irq=0, latch err_addr/err_we/err_tmo and set err_irq.
//    If err_irq=1 already, keep the first error's data (no overwrite).
//  - err_clr clears err_irq. Simultaneous new error and err_clr: the new error is captured
//    and err_irq stays 1.
//  - m_err=0 whenever m_ack=0. Reset asserted mid-transfer: immediate IDLE, no ack issued.
// STRUCTURE
//  - Shared package eco32_bus_pkg: ECO32 memory map constants:
//    RAM 0x0000_0000/128MB, ROM 0x2000_0000/8MB,
//    TMR0/1 0x3000_0000/0x3000_1000, DSP 0x3010_0000, KBD 0x3020_0000,
//    SER0/1 0x3030_0000/0x3030_1000, BIO 0x3100_0000.
//    Also state encoding and bus width constants.
//  - Sub-module bus_dec: pure decoder (m_addr, BASE, MASK -> one-hot sel, any_hit).
//  - bus_switch holds the FSM, timeout counter, muxes and error capture.
// TESTING
//  1. Map RAM at 0x0000_0000, read 0x0000_0010, slave 0 acks in 2 cycles with 0xDEADBEEF
//     -> s_stb=0b1, m_din=0xDEADBEEF, m_ack=1, m_err=0, no irq.
//  2. Write to unmapped 0x4000_0000 -> s_stb=0, m_ack=m_err=1 in second cycle;
//     err_irq=1, err_addr=0x1000_0000, err_we=1, err_tmo=0.
//  3. TMO=8, slave never acks -> m_ack=m_err=1 on cycle 9 with s_stb dropped;
//     err_tmo=1. Slave ack at cycle 8 instead -> normal completion, m_err=0.
//  4. Two errors back-to-back without err_clr -> err_addr keeps the first address.
//     err_clr pulsed coincident with a third error -> err_irq stays 1,
//     third address captured.
//  5. Overlapping masks for slaves 2 and 5 -> only s_stb[2] asserted.
//     Back-to-back reads to slaves 1 then 3 -> two acks on consecutive transfers,
//     no dead cycle.
//  6. rst_n low during BUSY at cnt=5 -> all outputs 0 asynchronously;
//     after release the next access starts with cnt=0.

Source files
------------

// File: rtl/eco32_bus_pkg.sv
// ECO32 bus constants: memory map, FSM state encoding, bus widths and
// helpers that turn byte-address regions into word-address decode parameters.
package eco32_bus_pkg;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_ERR  = 2'd2
   } bus_state_t;

   // Byte-address bases and sizes of the ECO32 memory map
   localparam logic [31:0] RAM_BASE  = 32'h0000_0000;
   localparam logic [31:0] RAM_SIZE  = 32'h0800_0000;
   localparam logic [31:0] ROM_BASE  = 32'h2000_0000;
   localparam logic [31:0] ROM_SIZE  = 32'h0080_0000;
   localparam logic [31:0] TMR0_BASE = 32'h3000_0000;
   localparam logic [31:0] TMR1_BASE = 32'h3000_1000;
   localparam logic [31:0] DSP_BASE  = 32'h3010_0000;
   localparam logic [31:0] KBD_BASE  = 32'h3020_0000;
   localparam logic [31:0] SER0_BASE = 32'h3030_0000;
   localparam logic [31:0] SER1_BASE = 32'h3030_1000;
   localparam logic [31:0] BIO_BASE  = 32'h3100_0000;
   localparam logic [31:0] IO_SIZE   = 32'h0000_1000;

   function automatic logic [ADDR_W-1:0] word_of(input logic [31:0] byte_addr);
      return ADDR_W'(byte_addr >> 2);
   endfunction

   // Size must be a power of two of at least one word
   function automatic logic [ADDR_W-1:0] region_mask(input logic [31:0] size);
      return ~(ADDR_W'((size >> 2) - 32'd1));
   endfunction

endpackage

// File: rtl/bus_dec.sv
// Address decoder: compares the word address against every slave window and
// returns a one-hot select where the lowest matching slave index wins.
module bus_dec
   import eco32_bus_pkg::*;
#(
   parameter int                     NSLV = 12,
   parameter logic [ADDR_W*NSLV-1:0] BASE = '0,
   parameter logic [ADDR_W*NSLV-1:0] MASK = '0
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [NSLV-1:0]   sel,
   output logic              any_hit
);

   always_comb begin
      sel     = '0;
      any_hit = 1'b0;
      for (int i = 0; i < NSLV; i++) begin
         if (!any_hit &&
             (((addr ^ BASE[ADDR_W*i +: ADDR_W]) & MASK[ADDR_W*i +: ADDR_W]) == '0)) begin
            sel[i]  = 1'b1;
            any_hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/bus_switch.sv
// CPU-to-slave interconnect: decode, strobe/ack/data muxing, slave timeout,
// bus-error completion and sticky capture of the first faulting access.
module bus_switch
   import eco32_bus_pkg::*;
#(
   parameter int                     NSLV  = 12,
   parameter logic [ADDR_W*NSLV-1:0] BASE  = '0,
   parameter logic [ADDR_W*NSLV-1:0] MASK  = '0,
   parameter int                     TMO   = 255,
   parameter int                     TMO_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     m_stb,
   input  logic                     m_we,
   input  logic [ADDR_W-1:0]        m_addr,
   output logic [DATA_W-1:0]        m_din,
   output logic                     m_ack,
   output logic                     m_err,
   output logic [NSLV-1:0]          s_stb,
   input  logic [DATA_W*NSLV-1:0]   s_dout,
   input  logic [NSLV-1:0]          s_ack,
   output logic                     err_irq,
   output logic [ADDR_W-1:0]        err_addr,
   output logic                     err_we,
   output logic                     err_tmo,
   input  logic                     err_clr
);

   bus_state_t          state;
   logic [TMO_W-1:0]    cnt;
   logic [NSLV-1:0]     sel;
   logic                any_hit;
   logic                sel_ack;
   logic [DATA_W-1:0]   sel_dout;
   logic                timeout;
   logic                err_enter;

   bus_dec #(
      .NSLV (NSLV),
      .BASE (BASE),
      .MASK (MASK)
   ) u_dec (
      .addr    (m_addr),
      .sel     (sel),
      .any_hit (any_hit)
   );

   always_comb begin
      sel_ack  = 1'b0;
      sel_dout = '0;
      for (int i = 0; i < NSLV; i++) begin
         if (sel[i]) begin
            sel_ack  = sel_ack | s_ack[i];
            sel_dout = sel_dout | s_dout[DATA_W*i +: DATA_W];
         end
      end
   end

   assign timeout   = (cnt == TMO_W'(TMO - 1));
   assign err_enter = (state != ST_ERR) && m_stb && (!any_hit || (!sel_ack && timeout));

   // Outputs are gated by rst_n so they drop the moment reset is asserted
   always_comb begin
      s_stb = '0;
      m_ack = 1'b0;
      m_err = 1'b0;
      m_din = '0;
      if (rst_n) begin
         if (state == ST_ERR) begin
            m_ack = 1'b1;
            m_err = 1'b1;
         end else if (m_stb && any_hit) begin
            s_stb = sel;
            m_ack = sel_ack;
            m_din = sel_dout;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            ST_ERR: begin
               state <= ST_IDLE;
               cnt   <= '0;
            end
            default: begin
               if (!m_stb || sel_ack) begin
                  state <= ST_IDLE;
                  cnt   <= '0;
               end else if (err_enter) begin
                  state <= ST_ERR;
                  cnt   <= '0;
               end else begin
                  state <= ST_BUSY;
                  cnt   <= cnt + TMO_W'(1);
               end
            end
         endcase
      end
   end

   // A hit that still errors can only be a timeout, so any_hit doubles as the cause
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_irq  <= 1'b0;
         err_addr <= '0;
         err_we   <= 1'b0;
         err_tmo  <= 1'b0;
      end else if (err_enter && (!err_irq || err_clr)) begin
         err_irq  <= 1'b1;
         err_addr <= m_addr;
         err_we   <= m_we;
         err_tmo  <= any_hit;
      end else if (err_clr) begin
         err_irq  <= 1'b0;
      end
   end

endmodule

// File: tb/tb_bus_switch.sv
// Self-checking bench for bus_switch: vector table, directed corner sequences
// and randomized transactions against a transaction-level reference model.
module tb_bus_switch;
   import eco32_bus_pkg::*;

   localparam int NSLV  = 6;
   localparam int TMO   = 8;
   localparam int TMO_W = 8;

   // Slave 5 is a wide window overlapping both timers so priority can be observed
   localparam logic [30*NSLV-1:0] BASE = {word_of(32'h3000_0000), word_of(DSP_BASE),
                                          word_of(TMR1_BASE), word_of(TMR0_BASE),
                                          word_of(ROM_BASE), word_of(RAM_BASE)};
   localparam logic [30*NSLV-1:0] MASK = {region_mask(32'h0010_0000), region_mask(IO_SIZE),
                                          region_mask(IO_SIZE), region_mask(IO_SIZE),
                                          region_mask(ROM_SIZE), region_mask(RAM_SIZE)};

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 m_stb, m_we, m_ack, m_err;
   logic [29:0]          m_addr;
   logic [31:0]          m_din;
   logic [NSLV-1:0]      s_stb, s_ack;
   logic [32*NSLV-1:0]   s_dout;
   logic                 err_irq, err_we, err_tmo, err_clr;
   logic [29:0]          err_addr;

   int checks   = 0;
   int failures = 0;

   logic [31:0] slv_data [NSLV];
   logic [31:0] r_base   [NSLV];
   logic [31:0] r_size   [NSLV];
   logic [31:0] unm      [7];

   logic        mdl_irq, mdl_we, mdl_tmo;
   logic [29:0] mdl_addr;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      int          slave;
   } vec_t;
   vec_t vecs [12];

   logic [31:0]     a;
   logic            rw;
   int              sl, lat, r;
   logic [NSLV-1:0] oh, noise;
   logic [29:0]     first_addr;

   bus_switch #(
      .NSLV  (NSLV),
      .BASE  (BASE),
      .MASK  (MASK),
      .TMO   (TMO),
      .TMO_W (TMO_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .m_stb    (m_stb),
      .m_we     (m_we),
      .m_addr   (m_addr),
      .m_din    (m_din),
      .m_ack    (m_ack),
      .m_err    (m_err),
      .s_stb    (s_stb),
      .s_dout   (s_dout),
      .s_ack    (s_ack),
      .err_irq  (err_irq),
      .err_addr (err_addr),
      .err_we   (err_we),
      .err_tmo  (err_tmo),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "[TB] watchdog");
   end

   // Reference decode works on byte ranges rather than mask compares
   function automatic int ref_slave(input logic [31:0] addr);
      for (int i = 0; i < NSLV; i++) begin
         if ({1'b0, addr} >= {1'b0, r_base[i]} &&
             {1'b0, addr} <  ({1'b0, r_base[i]} + {1'b0, r_size[i]}))
            return i;
      end
      return -1;
   endfunction

   function automatic logic rnd_clr();
      return ($urandom_range(0, 7) == 0);
   endfunction

   task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic loadData();
      for (int i = 0; i < NSLV; i++) s_dout[32*i +: 32] = slv_data[i];
   endtask

   task automatic applyStimulus(input logic stb, input logic we, input logic [31:0] byte_addr,
                                input logic [NSLV-1:0] ack, input logic clr);
      m_stb   = stb;
      m_we    = we;
      m_addr  = byte_addr[31:2];
      s_ack   = ack;
      err_clr = clr;
   endtask

   task automatic checkOutput(input string name, input logic [NSLV-1:0] x_stb, input logic x_ack,
                              input logic x_err, input logic [31:0] x_din);
      checkVal({name, ".s_stb"}, 64'(s_stb), 64'(x_stb));
      checkVal({name, ".m_ack"}, 64'(m_ack), 64'(x_ack));
      checkVal({name, ".m_err"}, 64'(m_err), 64'(x_err));
      checkVal({name, ".m_din"}, 64'(m_din), 64'(x_din));
      checkVal({name, ".err_irq"}, 64'(err_irq), 64'(mdl_irq));
      checkVal({name, ".err_addr"}, 64'(err_addr), 64'(mdl_addr));
      checkVal({name, ".err_we"}, 64'(err_we), 64'(mdl_we));
      checkVal({name, ".err_tmo"}, 64'(err_tmo), 64'(mdl_tmo));
   endtask

   // One bus cycle: drive, check mid-cycle, clock, then advance the error-capture model
   task automatic simCycle(input string name, input logic stb, input logic we,
                           input logic [31:0] byte_addr, input logic [NSLV-1:0] ack,
                           input logic clr, input logic [NSLV-1:0] x_stb, input logic x_ack,
                           input logic x_err, input logic [31:0] x_din,
                           input logic err_now, input logic tmo_now);
      applyStimulus(stb, we, byte_addr, ack, clr);
      @(negedge clk);
      checkOutput(name, x_stb, x_ack, x_err, x_din);
      @(posedge clk);
      #1;
      if (err_now && (!mdl_irq || clr)) begin
         mdl_irq  = 1'b1;
         mdl_addr = byte_addr[31:2];
         mdl_we   = we;
         mdl_tmo  = tmo_now;
      end else if (clr) begin
         mdl_irq = 1'b0;
      end
   endtask

   task automatic idleCycle(input string name, input logic clr);
      simCycle(name, 1'b0, 1'b0, 32'h0, NSLV'($urandom), clr, '0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   initial begin
      r_base[0] = RAM_BASE;     r_size[0] = RAM_SIZE;
      r_base[1] = ROM_BASE;     r_size[1] = ROM_SIZE;
      r_base[2] = TMR0_BASE;    r_size[2] = IO_SIZE;
      r_base[3] = TMR1_BASE;    r_size[3] = IO_SIZE;
      r_base[4] = DSP_BASE;     r_size[4] = IO_SIZE;
      r_base[5] = 32'h3000_0000; r_size[5] = 32'h0010_0000;
      unm[0] = 32'h0800_0000; unm[1] = 32'h1000_0000; unm[2] = 32'h2080_0000;
      unm[3] = 32'h3010_1000; unm[4] = KBD_BASE;      unm[5] = 32'h4000_0000;
      unm[6] = 32'hF000_0000;

      vecs[0]  = '{32'h0000_0010, 1'b0, 0};
      vecs[1]  = '{32'h07FF_FFFC, 1'b1, 0};
      vecs[2]  = '{32'h0800_0000, 1'b0, -1};
      vecs[3]  = '{32'h2000_0000, 1'b0, 1};
      vecs[4]  = '{32'h207F_FFFC, 1'b1, 1};
      vecs[5]  = '{32'h2080_0000, 1'b1, -1};
      vecs[6]  = '{32'h3000_0010, 1'b0, 2};
      vecs[7]  = '{32'h3000_1FFC, 1'b0, 3};
      vecs[8]  = '{32'h3000_8000, 1'b1, 5};
      vecs[9]  = '{32'h3010_0004, 1'b0, 4};
      vecs[10] = '{32'h3010_1000, 1'b0, -1};
      vecs[11] = '{32'h4000_0000, 1'b1, -1};

      for (int i = 0; i < NSLV; i++) slv_data[i] = 32'hC0DE_0000 | 32'(i);
      slv_data[0] = 32'hDEAD_BEEF;
      loadData();
      mdl_irq = 1'b0; mdl_addr = '0; mdl_we = 1'b0; mdl_tmo = 1'b0;

      // Reset with a live, acked access pending: everything must stay quiet
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b0, 32'h0000_0010, '1, 1'b0);
      #1 rst_n = 1'b0;
      #12;
      checkOutput("reset", '0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] vector table");
      foreach (vecs[v]) begin
         idleCycle($sformatf("vec%0d_idle", v), 1'b0);
         if (vecs[v].slave >= 0) begin
            oh = '0;
            oh[vecs[v].slave] = 1'b1;
            simCycle($sformatf("vec%0d", v), 1'b1, vecs[v].we, vecs[v].addr, '1, 1'b0,
                     oh, 1'b1, 1'b0, slv_data[vecs[v].slave], 1'b0, 1'b0);
         end else begin
            simCycle($sformatf("vec%0d_dec", v), 1'b1, vecs[v].we, vecs[v].addr, '1, 1'b0,
                     '0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            simCycle($sformatf("vec%0d_err", v), 1'b1, vecs[v].we, vecs[v].addr, '1, 1'b1,
                     '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
         end
      end

      $display("[TB] RAM read with two-cycle slave");
      idleCycle("t1_idle", 1'b0);
      simCycle("t1_c0", 1'b1, 1'b0, 32'h0000_0010, '0, 1'b0, 6'b000001, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      simCycle("t1_c1", 1'b1, 1'b0, 32'h0000_0010, 6'b000001, 1'b0, 6'b000001, 1'b1, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
      checkVal("t1_no_irq", 64'(err_irq), 64'(0));

      $display("[TB] unmapped write");
      simCycle("t2_c0", 1'b1, 1'b1, 32'h4000_0000, '0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      simCycle("t2_c1", 1'b1, 1'b1, 32'h4000_0000, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      checkVal("t2_irq", 64'(err_irq), 64'(1));
      checkVal("t2_addr", 64'(err_addr), 64'(30'h1000_0000));
      checkVal("t2_we", 64'(err_we), 64'(1));
      checkVal("t2_tmo", 64'(err_tmo), 64'(0));
      idleCycle("t2_clr", 1'b1);

      $display("[TB] slave timeout");
      for (int k = 0; k < TMO; k++)
         simCycle($sformatf("t3a_k%0d", k), 1'b1, 1'b0, 32'h2000_0100, '0, 1'b0,
                  6'b000010, 1'b0, 1'b0, slv_data[1], (k == TMO - 1), 1'b1);
      simCycle("t3a_err", 1'b1, 1'b0, 32'h2000_0100, 6'b000010, 1'b1, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      checkVal("t3a_tmo", 64'(err_tmo), 64'(1));
      for (int k = 0; k < TMO; k++)
         simCycle($sformatf("t3b_k%0d", k), 1'b1, 1'b1, 32'h2000_0200,
                  (k == TMO - 1) ? 6'b000010 : 6'b000000, 1'b0,
                  6'b000010, (k == TMO - 1), 1'b0, slv_data[1], 1'b0, 1'b0);
      checkVal("t3b_no_irq", 64'(err_irq), 64'(0));

      $display("[TB] sticky capture and clear collision");
      simCycle("t4_a0", 1'b1, 1'b0, 32'h4000_0000, '0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      simCycle("t4_a1", 1'b1, 1'b0, 32'h4000_0000, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      simCycle("t4_b0", 1'b1, 1'b1, 32'h5000_0004, '0, 1'b0, '0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      simCycle("t4_b1", 1'b1, 1'b1, 32'h5000_0004, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      checkVal("t4_keep_first", 64'(err_addr), 64'(30'h1000_0000));
      checkVal("t4_keep_we", 64'(err_we), 64'(0));
      simCycle("t4_c0", 1'b1, 1'b0, 32'h6000_0008, '0, 1'b1, '0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      simCycle("t4_c1", 1'b1, 1'b0, 32'h6000_0008, '0, 1'b0, '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
      checkVal("t4_third_irq", 64'(err_irq), 64'(1));
      checkVal("t4_third_addr", 64'(err_addr), 64'(30'h1800_0002));
      idleCycle("t4_clr", 1'b1);
      checkVal("t4_cleared", 64'(err_irq), 64'(0));

      $display("[TB] priority and back-to-back");
      slv_data[5] = 32'h5555_AAAA;
      loadData();
      simCycle("t5_ovl0", 1'b1, 1'b0, 32'h3000_0010, '0, 1'b0, 6'b000100, 1'b0, 1'b0, slv_data[2], 1'b0, 1'b0);
      simCycle("t5_ovl1", 1'b1, 1'b0, 32'h3000_0010, '1, 1'b0, 6'b000100, 1'b1, 1'b0, slv_data[2], 1'b0, 1'b0);
      simCycle("t5_s1", 1'b1, 1'b0, 32'h2000_0040, 6'b000010, 1'b0, 6'b000010, 1'b1, 1'b0, slv_data[1], 1'b0, 1'b0);
      simCycle("t5_s3", 1'b1, 1'b0, 32'h3000_1000, 6'b001000, 1'b0, 6'b001000, 1'b1, 1'b0, slv_data[3], 1'b0, 1'b0);

      $display("[TB] reset during a stalled access");
      first_addr = err_addr;
      for (int k = 0; k < 5; k++)
         simCycle($sformatf("t6_k%0d", k), 1'b1, 1'b0, 32'h3010_0000, '0, 1'b0,
                  6'b010000, 1'b0, 1'b0, slv_data[4], 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 32'h3010_0000, '1, 1'b0);
      #1;
      checkVal("t6_pre_ack", 64'(m_ack), 64'(1));
      checkVal("t6_pre_erraddr", 64'(err_addr), 64'(first_addr));
      #1 rst_n = 1'b0;
      #1;
      mdl_irq = 1'b0; mdl_addr = '0; mdl_we = 1'b0; mdl_tmo = 1'b0;
      checkOutput("t6_async", '0, 1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0, '0, 1'b0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int k = 0; k < TMO; k++)
         simCycle($sformatf("t6_post_k%0d", k), 1'b1, 1'b0, 32'h3010_0000,
                  (k == TMO - 1) ? 6'b010000 : 6'b000000, 1'b0,
                  6'b010000, (k == TMO - 1), 1'b0, slv_data[4], 1'b0, 1'b0);

      $display("[TB] randomized transactions");
      for (int t = 0; t < 150; t++) begin
         if ($urandom_range(0, 3) == 0) idleCycle($sformatf("rnd%0d_idle", t), rnd_clr());
         for (int i = 0; i < NSLV; i++) slv_data[i] = $urandom;
         loadData();
         if ($urandom_range(0, 4) == 0) begin
            a = unm[$urandom_range(0, 6)] + (32'($urandom_range(0, 255)) << 2);
         end else begin
            r = int'($urandom_range(0, NSLV - 1));
            a = r_base[r] + (($urandom % r_size[r]) & 32'hFFFF_FFFC);
         end
         rw = 1'($urandom_range(0, 1));
         sl = ref_slave(a);
         if (sl < 0) begin
            simCycle($sformatf("rnd%0d_dec", t), 1'b1, rw, a, NSLV'($urandom), rnd_clr(),
                     '0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
            simCycle($sformatf("rnd%0d_err", t), 1'b1, rw, a, NSLV'($urandom), rnd_clr(),
                     '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
         end else begin
            lat = int'($urandom_range(0, TMO + 1));
            oh = '0;
            oh[sl] = 1'b1;
            for (int k = 0; k < TMO; k++) begin
               noise = NSLV'($urandom);
               noise[sl] = (k == lat);
               simCycle($sformatf("rnd%0d_k%0d", t, k), 1'b1, rw, a, noise, rnd_clr(),
                        oh, (k == lat), 1'b0, slv_data[sl], (k == TMO - 1) && (k != lat), 1'b1);
               if (k == lat) break;
            end
            if (lat >= TMO)
               simCycle($sformatf("rnd%0d_tmo", t), 1'b1, rw, a, NSLV'($urandom), rnd_clr(),
                        '0, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
